// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM encodings and counter-width helper for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// rtl/serial_adder_digit_adder.sv - combinational DIGIT-bit ripple adder slice
// Exposes the carry into the slice MSB so the top can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, DIGIT bits per clock, LSB digit first
// Optional subtract support via SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;

  logic [DIGIT-1:0]       w_dsum;
  logic                   w_dcout;
  logic                   w_dcmsb;
  logic [WIDTH+DIGIT-1:0] w_shift;
  logic [WIDTH-1:0]       w_acc_next;
  logic [WIDTH-1:0]       w_b_load;
  logic                   w_c_load;

  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (r_cnt == LAST) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_RUN);
    done = (r_state == ST_DONE);
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as A + ~B + 1; the forced carry replaces c_in.
  assign w_b_load = sub ? ~in_2 : in_2;
  assign w_c_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load = in_2;
  assign w_c_load = c_in;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dcout),
    .o_cmsb (w_dcmsb)
  );

  // New digit enters at the top; after N shifts digit 0 lands at the LSB.
  assign w_shift    = {w_dsum, r_acc};
  assign w_acc_next = w_shift[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= in_1;
      r_b     <= w_b_load;
      r_acc   <= '0;
      r_carry <= w_c_load;
    end else if (r_state == ST_RUN) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_next;
      r_carry <= w_dcout;
      if (r_cnt == LAST) begin
        r_sum      <= w_acc_next;
        r_c_out    <= w_dcout;
        r_overflow <= w_dcout ^ w_dcmsb;
      end
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_overflow;

endmodule
